// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter that shares one 8-to-1 mux among
// eight requesters.
// - Grants one requester at a time.
// - Drives select_bits to the index of the granted requester.
// - Holds a dead gap of GAP_CYCLES idle cycles between grants so the mux
//   output can settle.
// Optional build macro MUX8_ARB_TIMEOUT_EN adds a hold limit (MAX_HOLD).
// When that limit is reached, the grant is revoked and timeout pulses high
// for one cycle. Without the macro, timeout stays low and a grant lasts
// until the requester releases it.
module mux8_rr_arbiter #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic [2:0] select_bits,
  output logic       timeout
);

  // Reject illegal configurations at elaboration time.
  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
    $error("mux8_rr_arbiter: GAP_CYCLES must be in 1..15");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("mux8_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] last_idx_q, last_idx_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic [2:0] sel_q, sel_d;
  logic       timeout_q, timeout_d;

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

  // Round-robin scan: pick the first requester after last_idx.
  // The offset of 8 wraps back to last_idx, giving it the lowest priority.
  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;

  // Pick the next requester to serve in round-robin order.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    pick_found = 1'b0;
    pick_idx   = last_idx_q;
    cand       = last_idx_q;
    for (int k = 1; k <= 8; k++) begin
      cand = last_idx_q + 3'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Compute the next state and the next registered outputs.
  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    gap_cnt_d  = gap_cnt_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    sel_d      = sel_q;
    timeout_d  = 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = 8'(1) << pick_idx;
          valid_d    = 1'b1;
          sel_d      = pick_idx;
          last_idx_d = pick_idx;
          state_d    = GRANT;
`ifdef MUX8_ARB_TIMEOUT_EN
          hold_cnt_d = 8'd0;
`endif
        end
      end

      GRANT: begin
        // Only the current owner's request line matters while it holds the mux.
        if (!req[sel_q]) begin
          grant_d   = 8'h00;
          valid_d   = 1'b0;
          gap_cnt_d = GAP_LOAD;
          state_d   = GAP;
`ifdef MUX8_ARB_TIMEOUT_EN
        end else if (hold_cnt_q == HOLD_LIMIT) begin
          // Forced revoke; last_idx keeps the preempted index so it ranks last.
          grant_d   = 8'h00;
          valid_d   = 1'b0;
          gap_cnt_d = GAP_LOAD;
          timeout_d = 1'b1;
          state_d   = GAP;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end

      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_idx_q <= 3'd7;
      gap_cnt_q  <= 4'd0;
      grant_q    <= 8'h00;
      valid_q    <= 1'b0;
      sel_q      <= 3'd0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments, so every flop samples
      // its pre-edge value regardless of statement order.
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef MUX8_ARB_TIMEOUT_EN
  // Hold counter register, present only in timeout builds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt_q <= 8'd0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`endif

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign select_bits = sel_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter (GAP_CYCLES = 1, MAX_HOLD = 4).
// Table-driven vectors plus hand-written reset sequences.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] select_bits;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] grant;
    logic       valid;
    logic [2:0] sel;
    logic       to;
  } vec_t;

  vec_t t_basic[$];
  vec_t t_rr[$];
  vec_t t_single[$];
  vec_t t_hold[$];

  mux8_rr_arbiter #(
    .GAP_CYCLES(1),
    .MAX_HOLD  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .select_bits(select_bits),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] g, input logic v,
                            input logic [2:0] s, input logic t);
    check({name, " grant"},       32'(grant),       32'(g));
    check({name, " grant_valid"}, 32'(grant_valid), 32'(v));
    check({name, " select_bits"}, 32'(select_bits), 32'(s));
    check({name, " timeout"},     32'(timeout),     32'(t));
  endtask

  // Drive req, let one rising edge sample it, then check the outputs 1 ns later.
  task automatic apply(input string name, input logic [7:0] r, input logic [7:0] g,
                       input logic v, input logic [2:0] s, input logic t);
    req = r;
    @(posedge clk);
    #1;
    check_outs(name, g, v, s, t);
  endtask

  task automatic run_table(input string tag, input vec_t q[$]);
    for (int i = 0; i < q.size(); i++) begin
      apply($sformatf("%s[%0d]", tag, i), q[i].req, q[i].grant, q[i].valid, q[i].sel, q[i].to);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] r, input logic [7:0] g, input logic v,
                              input logic [2:0] s, input logic t);
    vec_t x;
    x.req = r; x.grant = g; x.valid = v; x.sel = s; x.to = t;
    return x;
  endfunction

  initial begin
    // Single requester 0: three-cycle hold, release, then re-request inside the gap.
    t_basic.push_back(mk(8'h01, 8'h01, 1, 3'd0, 0));
    t_basic.push_back(mk(8'h01, 8'h01, 1, 3'd0, 0));
    t_basic.push_back(mk(8'h01, 8'h01, 1, 3'd0, 0));
    t_basic.push_back(mk(8'h00, 8'h00, 0, 3'd0, 0)); // release edge
    t_basic.push_back(mk(8'h01, 8'h00, 0, 3'd0, 0)); // gap edge: new request waits
    t_basic.push_back(mk(8'h01, 8'h01, 1, 3'd0, 0)); // IDLE edge: re-grant
    t_basic.push_back(mk(8'h00, 8'h00, 0, 3'd0, 0));
    t_basic.push_back(mk(8'h00, 8'h00, 0, 3'd0, 0));
    t_basic.push_back(mk(8'h00, 8'h00, 0, 3'd0, 0)); // idle, select_bits kept

    // All eight request (after a fresh reset): expected order 0..7 then wrap to 0.
    for (int k = 0; k < 9; k++) begin
      logic [2:0] idx;
      logic [7:0] one;
      idx = 3'(k % 8);
      one = 8'(1) << idx;
      t_rr.push_back(mk(8'hFF, one, 1, idx, 0));
      t_rr.push_back(mk(8'hFF & ~one, 8'h00, 0, idx, 0));
      t_rr.push_back(mk(8'hFF, 8'h00, 0, idx, 0));
    end

    // Sole requester 5, released after two cycles: re-granted every 4 cycles.
    for (int k = 0; k < 2; k++) begin
      t_single.push_back(mk(8'h20, 8'h20, 1, 3'd5, 0));
      t_single.push_back(mk(8'h20, 8'h20, 1, 3'd5, 0));
      t_single.push_back(mk(8'h00, 8'h00, 0, 3'd5, 0));
      t_single.push_back(mk(8'h20, 8'h00, 0, 3'd5, 0));
    end
    t_single.push_back(mk(8'h20, 8'h20, 1, 3'd5, 0));

    // req = 8'h06 held continuously.
`ifdef MUX8_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) t_hold.push_back(mk(8'h06, 8'h02, 1, 3'd1, 0));
    t_hold.push_back(mk(8'h06, 8'h00, 0, 3'd1, 1)); // revoke, timeout pulse
    t_hold.push_back(mk(8'h06, 8'h00, 0, 3'd1, 0)); // gap
    for (int k = 0; k < 4; k++) t_hold.push_back(mk(8'h06, 8'h04, 1, 3'd2, 0));
    t_hold.push_back(mk(8'h06, 8'h00, 0, 3'd2, 1));
    t_hold.push_back(mk(8'h06, 8'h00, 0, 3'd2, 0));
    t_hold.push_back(mk(8'h06, 8'h02, 1, 3'd1, 0)); // back to index 1
`else
    for (int k = 0; k < 13; k++) t_hold.push_back(mk(8'h06, 8'h02, 1, 3'd1, 0));
`endif

    reset = 1'b1;
    req   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 8'h00, 0, 3'd0, 0);
    reset = 1'b0;

    run_table("basic", t_basic);

    // Fresh reset so the round-robin walk starts at index 0.
    reset = 1'b1;
    #1;
    check_outs("rr_reset", 8'h00, 0, 3'd0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_table("rr", t_rr);

    run_table("single", t_single);

    // Build a grant on index 3, then reset in the middle of it.
    apply("pre_rst_rel",  8'h00, 8'h00, 0, 3'd5, 0);
    apply("pre_rst_gap",  8'h00, 8'h00, 0, 3'd5, 0);
    apply("pre_rst_g3",   8'h08, 8'h08, 1, 3'd3, 0);
    apply("pre_rst_hold", 8'h08, 8'h08, 1, 3'd3, 0);
    reset = 1'b1;
    req   = 8'h88;
    #1;
    check_outs("mid_rst_async", 8'h00, 0, 3'd0, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("mid_rst_cyc%0d", k), 8'h00, 0, 3'd0, 0);
    end
    reset = 1'b0;
    apply("post_rst_g3",  8'h88, 8'h08, 1, 3'd3, 0);
    apply("post_rst_rel", 8'h80, 8'h00, 0, 3'd3, 0);
    apply("post_rst_gap", 8'h80, 8'h00, 0, 3'd3, 0);
    apply("post_rst_g7",  8'h80, 8'h80, 1, 3'd7, 0);
    apply("post_rst_rel7", 8'h00, 8'h00, 0, 3'd7, 0);
    apply("post_rst_gap7", 8'h00, 8'h00, 0, 3'd7, 0);

    run_table("hold", t_hold);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
